// File: rtl/ram_arbiter_pkg.sv
// Shared constants and types for the two-port RAM arbiter.
// RAM op codes, FSM states, port ids and the issue bundle.
package ram_arbiter_pkg;

    localparam int MEM_SIZE = 4096;

    localparam logic [1:0] RAM_NONE  = 2'b00;
    localparam logic [1:0] RAM_READ  = 2'b01;
    localparam logic [1:0] RAM_WRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_F = 1'b0,
        PORT_D = 1'b1
    } port_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } issue_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select between fetch (F) and data (D).
// RAM_ARB_RR_EN: round-robin on ties; otherwise D has fixed priority.
module ram_arb_pick
    import ram_arbiter_pkg::*;
(
    input  logic  f_req,
    input  logic  d_req,
`ifdef RAM_ARB_RR_EN
    input  port_t last_grant,
`endif
    output logic  grant_vld,
    output port_t grant
);

    always_comb begin
        grant_vld = f_req | d_req;
        grant     = PORT_D;
        unique case (1'b1)
            (f_req & ~d_req): grant = PORT_F;
            (d_req & ~f_req): grant = PORT_D;
            default: begin
`ifdef RAM_ARB_RR_EN
                grant = (last_grant == PORT_F) ? PORT_D : PORT_F;
`else
                grant = PORT_D;
`endif
            end
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer sharing one RAM port between F and D.
// Optional RAM_ARB_RR_EN selects round-robin arbitration.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int MEM_SIZE = ram_arbiter_pkg::MEM_SIZE
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_f_req,
    input  logic [31:0] i_f_addr,
    output logic        o_f_ack,
    output logic [31:0] o_f_rdata,
    output logic        o_f_err,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    output logic        o_d_ack,
    output logic [31:0] o_d_rdata,
    output logic        o_d_err,
    output logic [1:0]  o_ram_do,
    output logic [31:0] o_ram_addr,
    output logic [31:0] o_ram_val,
    input  logic [31:0] i_ram_val
);

    state_t      state, state_nx;
    issue_t      iss;
    port_t       who;
    port_t       grant;
    logic        grant_vld;
    logic        legal;
    logic [31:0] f_rdata_q, d_rdata_q;
    logic        f_err_q, d_err_q;

`ifdef RAM_ARB_RR_EN
    port_t       last_q;
`endif

    ram_arb_pick u_pick (
        .f_req      (i_f_req),
        .d_req      (i_d_req),
`ifdef RAM_ARB_RR_EN
        .last_grant (last_q),
`endif
        .grant_vld  (grant_vld),
        .grant      (grant)
    );

    // Unsigned 32-bit compare, so addresses near 2^32 stay illegal.
    assign legal = (iss.addr <= 32'(MEM_SIZE - 4));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (grant_vld) state_nx = ACCESS;
            ACCESS:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_ram_do   = RAM_NONE;
        o_ram_addr = iss.addr;
        o_ram_val  = iss.wdata;
        o_f_ack    = 1'b0;
        o_d_ack    = 1'b0;
        o_f_rdata  = f_rdata_q;
        o_d_rdata  = d_rdata_q;
        o_f_err    = f_err_q;
        o_d_err    = d_err_q;
        if (state == ACCESS && legal) o_ram_do = iss.op;
        if (state == DONE) begin
            o_f_ack = (who == PORT_F);
            o_d_ack = (who == PORT_D);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            iss       <= '0;
            who       <= PORT_F;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
            f_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
`ifdef RAM_ARB_RR_EN
            last_q    <= PORT_F;
`endif
        end else begin
            state <= state_nx;
            if (state == IDLE && grant_vld) begin
                who <= grant;
`ifdef RAM_ARB_RR_EN
                last_q <= grant;
`endif
                if (grant == PORT_D) begin
                    iss.op    <= i_d_we ? RAM_WRITE : RAM_READ;
                    iss.addr  <= i_d_addr;
                    iss.wdata <= i_d_wdata;
                end else begin
                    iss.op   <= RAM_READ;
                    iss.addr <= i_f_addr;
                end
            end
            if (state == ACCESS) begin
                if (who == PORT_F) begin
                    f_err_q <= ~legal;
                    if (!legal) f_rdata_q <= '0;
                    else if (iss.op == RAM_READ) f_rdata_q <= i_ram_val;
                end else begin
                    d_err_q <= ~legal;
                    if (!legal) d_rdata_q <= '0;
                    else if (iss.op == RAM_READ) d_rdata_q <= i_ram_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized scoreboard bench for ram_arbiter with a behavioural RAM.
// Honours RAM_ARB_RR_EN to pick the expected arbitration rule.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int MSZ = 4096;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_f_req = 1'b0;
    logic [31:0] i_f_addr = '0;
    logic        o_f_ack;
    logic [31:0] o_f_rdata;
    logic        o_f_err;
    logic        i_d_req = 1'b0;
    logic        i_d_we = 1'b0;
    logic [31:0] i_d_addr = '0;
    logic [31:0] i_d_wdata = '0;
    logic        o_d_ack;
    logic [31:0] o_d_rdata;
    logic        o_d_err;
    logic [1:0]  o_ram_do;
    logic [31:0] o_ram_addr;
    logic [31:0] o_ram_val;
    logic [31:0] i_ram_val;

    always #5 i_clk = ~i_clk;

    ram_arbiter #(.MEM_SIZE(MSZ)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_f_req(i_f_req), .i_f_addr(i_f_addr),
        .o_f_ack(o_f_ack), .o_f_rdata(o_f_rdata), .o_f_err(o_f_err),
        .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr),
        .i_d_wdata(i_d_wdata),
        .o_d_ack(o_d_ack), .o_d_rdata(o_d_rdata), .o_d_err(o_d_err),
        .o_ram_do(o_ram_do), .o_ram_addr(o_ram_addr),
        .o_ram_val(o_ram_val), .i_ram_val(i_ram_val)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return a <= 32'(MSZ - 4);
    endfunction

    // Behavioural RAM seen by the DUT, and the model's own memory image
    logic [7:0] ram_mem [MSZ];
    logic [7:0] mdl_mem [MSZ];

    always_comb begin
        i_ram_val = '0;
        if (in_range(o_ram_addr))
            for (int k = 0; k < 4; k++)
                i_ram_val[31-8*k -: 8] = ram_mem[int'(o_ram_addr) + k];
    end

    always @(posedge i_clk)
        if (o_ram_do == RAM_WRITE && in_range(o_ram_addr))
            for (int k = 0; k < 4; k++)
                ram_mem[int'(o_ram_addr) + k] <= o_ram_val[31-8*k -: 8];

    typedef struct {
        int          cyc;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] val;
    } bus_t;

    typedef struct {
        int          cyc;
        bit          port;
        bit          err;
        logic [31:0] f_rd;
        logic [31:0] d_rd;
    } rsp_t;

    bus_t busq[$];
    rsp_t rspq[$];

    // Reference model: a grant every 3 cycles, effects at the access cycle
    initial begin
        int          phase;
        bit          m_port, m_last, ok;
        logic [1:0]  m_op;
        logic [31:0] m_addr, m_wd, m_frd, m_drd, w;
        phase = 0; m_last = 0; m_frd = 0; m_drd = 0;
        m_port = 0; m_op = RAM_NONE; m_addr = 0; m_wd = 0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                phase = 0; m_last = 0; m_frd = 0; m_drd = 0;
                busq.delete();
                rspq.delete();
            end else if (phase == 2) begin
                ok = in_range(m_addr);
                if (!ok) begin
                    if (m_port) m_drd = 0; else m_frd = 0;
                end else if (m_op == RAM_WRITE) begin
                    for (int k = 0; k < 4; k++)
                        mdl_mem[int'(m_addr) + k] = m_wd[31-8*k -: 8];
                end else begin
                    for (int k = 0; k < 4; k++)
                        w[31-8*k -: 8] = mdl_mem[int'(m_addr) + k];
                    if (m_port) m_drd = w; else m_frd = w;
                end
                rspq.push_back('{cyc + 1, m_port, !ok, m_frd, m_drd});
                phase = 1;
            end else if (phase == 1) begin
                phase = 0;
            end else if (i_f_req || i_d_req) begin
                if (i_f_req && i_d_req) begin
`ifdef RAM_ARB_RR_EN
                    m_port = !m_last;
`else
                    m_port = 1;
`endif
                end else begin
                    m_port = i_d_req;
                end
                m_last = m_port;
                m_op   = (m_port && i_d_we) ? RAM_WRITE : RAM_READ;
                m_addr = m_port ? i_d_addr : i_f_addr;
                if (m_port) m_wd = i_d_wdata;
                busq.push_back('{cyc + 1,
                                 in_range(m_addr) ? m_op : RAM_NONE,
                                 m_addr, m_wd});
                phase = 2;
            end
        end
    end

    // Monitor: RAM port every cycle, responses on each ack
    initial begin
        bus_t b;
        rsp_t r;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                chk("rst_do", o_ram_do, RAM_NONE);
                chk("rst_acks", {o_f_ack, o_d_ack, o_f_err, o_d_err}, 0);
                chk("rst_rdata", {o_f_rdata, o_d_rdata}, 0);
                chk("rst_ram_bus", {o_ram_addr, o_ram_val}, 0);
            end else begin
                if (busq.size() > 0 && busq[0].cyc == cyc) begin
                    b = busq.pop_front();
                    chk("ram_do", o_ram_do, b.op);
                    if (b.op != RAM_NONE) chk("ram_addr", o_ram_addr, b.addr);
                    if (b.op == RAM_WRITE) chk("ram_val", o_ram_val, b.val);
                end else begin
                    chk("ram_do_idle", o_ram_do, RAM_NONE);
                end
                if (o_f_ack || o_d_ack) begin
                    if (rspq.size() == 0) begin
                        chk("spurious_ack", {o_f_ack, o_d_ack}, 0);
                    end else begin
                        r = rspq.pop_front();
                        chk("ack_port", {o_f_ack, o_d_ack},
                            r.port ? 2'b01 : 2'b10);
                        chk("ack_cycle", cyc, r.cyc);
                        chk("ack_err", r.port ? o_d_err : o_f_err, r.err);
                        chk("f_rdata", o_f_rdata, r.f_rd);
                        chk("d_rdata", o_d_rdata, r.d_rd);
                    end
                end else if (rspq.size() > 0 && rspq[0].cyc <= cyc) begin
                    r = rspq.pop_front();
                    chk("missing_ack", {o_f_ack, o_d_ack},
                        r.port ? 2'b01 : 2'b10);
                end
            end
        end
    end

    function automatic logic [31:0] rand_addr(input bit legal_only);
        int sel;
        sel = legal_only ? $urandom_range(5) : $urandom_range(9);
        case (sel)
            0, 1, 2: return 32'($urandom_range(60));
            3, 4, 5: return 32'($urandom_range(MSZ - 4));
            6:       return 32'(MSZ - 4);
            7:       return 32'(MSZ - 3);
            8:       return 32'hFFFF_FFFE;
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_ack(input bit d);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge i_clk);
            got = d ? o_d_ack : o_f_ack;
        end
        chk(d ? "d_ack_wait" : "f_ack_wait", got, 1);
        @(posedge i_clk);
        #1;
        if (d) i_d_req = 0; else i_f_req = 0;
    endtask

    task automatic d_txn(input bit we, input logic [31:0] a,
                         input logic [31:0] wd);
        @(posedge i_clk);
        #1;
        i_d_req = 1; i_d_we = we; i_d_addr = a; i_d_wdata = wd;
        wait_ack(1);
    endtask

    task automatic f_txn(input logic [31:0] a);
        @(posedge i_clk);
        #1;
        i_f_req = 1; i_f_addr = a;
        wait_ack(0);
    endtask

    // Requests persist until acked; a freed port re-requests with pf/pd %
    task automatic run_random(input int n, input int pf, input int pd,
                              input bit legal_only);
        bit fa, da;
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            fa = o_f_ack;
            da = o_d_ack;
            @(posedge i_clk);
            #1;
            if (fa) i_f_req = 0;
            if (da) i_d_req = 0;
            if (!i_f_req && $urandom_range(99) < pf) begin
                i_f_req = 1;
                i_f_addr = rand_addr(legal_only);
            end
            if (!i_d_req && $urandom_range(99) < pd) begin
                i_d_req = 1;
                i_d_we = 1'($urandom_range(1));
                i_d_addr = rand_addr(legal_only);
                i_d_wdata = $urandom;
            end
        end
    endtask

    task automatic pulse_reset();
        @(posedge i_clk);
        #2;
        i_rst_n = 0;
        repeat (2) @(posedge i_clk);
        #3;
        i_rst_n = 1;
    endtask

    initial begin
        logic [7:0] old;
        bit seen;
        for (int i = 0; i < MSZ; i++) begin
            ram_mem[i] = 8'($urandom);
            mdl_mem[i] = ram_mem[i];
        end
        repeat (3) @(posedge i_clk);
        #3;
        i_rst_n = 1;

        d_txn(1, 32'h10, 32'hDEAD_BEEF);
        d_txn(0, 32'h10, 32'h0);
        chk("byte_0x10", ram_mem[16], 8'hDE);

        {ram_mem[256], ram_mem[257], ram_mem[258], ram_mem[259]} = 32'h1234_5678;
        {mdl_mem[256], mdl_mem[257], mdl_mem[258], mdl_mem[259]} = 32'h1234_5678;
        f_txn(32'h100);
        chk("f_read_0x100", o_f_rdata, 32'h1234_5678);

        // Both requesters held high straight out of reset
        @(posedge i_clk);
        #2;
        i_rst_n = 0;
        i_f_req = 1; i_f_addr = rand_addr(1);
        i_d_req = 1; i_d_we = 0; i_d_addr = rand_addr(1);
        repeat (2) @(posedge i_clk);
        #3;
        i_rst_n = 1;
        run_random(13, 100, 100, 1);
        run_random(12, 100, 0, 1);
        run_random(20, 0, 0, 1);

        d_txn(1, 32'd4093, 32'hA5A5_5A5A);
        d_txn(0, 32'hFFFF_FFFE, 32'h0);
        chk("d_rd_wrap_rdata", o_d_rdata, 0);
        d_txn(0, 32'd4092, 32'h0);

        // Reset during a write's ACCESS cycle
        old = ram_mem[32];
        @(posedge i_clk);
        #1;
        i_d_req = 1; i_d_we = 1; i_d_addr = 32'h20; i_d_wdata = 32'hCAFE_F00D;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge i_clk);
            #1;
            seen = (o_ram_do == RAM_WRITE);
        end
        chk("mid_write_seen", seen, 1);
        #1;
        i_rst_n = 0;
        i_d_req = 0;
        #1;
        chk("rst_do_now", o_ram_do, RAM_NONE);
        chk("rst_ack_now", {o_f_ack, o_d_ack}, 0);
        @(posedge i_clk);
        #1;
        chk("no_commit", ram_mem[32], old);
        #2;
        i_rst_n = 1;

        run_random(600, 40, 40, 0);
        run_random(30, 0, 0, 0);
        pulse_reset();
        run_random(300, 70, 70, 0);
        run_random(30, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer for the CPU's byte-addressed `ram`. It shares the single RAM port between the instruction-fetch requester (F, read-only) and the load/store requester (D, read/write), and drives the RAM's `i_do`/`i_addr`/`i_val`. It registers the RAM's combinational `o_val` into a held response and range-checks addresses. It sits between the core's fetch/LSU stages and `ram`.

## Interface
Parameters:
- `MEM_SIZE`, default 4096: RAM size in bytes. Must match the `MEM_SIZE` used by `ram`.

Ports:
- `i_clk`, in, 1: clock, rising edge.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_f_req`, in, 1: fetch request; held until `o_f_ack`.
- `i_f_addr`, in, 32: fetch byte address.
- `o_f_ack`, out, 1: one-cycle completion pulse for F.
- `o_f_rdata`, out, 32: fetch read word; valid with `o_f_ack` and held until the next F completion.
- `o_f_err`, out, 1: out-of-range flag; valid with `o_f_ack`.
- `i_d_req`, in, 1: data request; held until `o_d_ack`.
- `i_d_we`, in, 1: 1 = write, 0 = read.
- `i_d_addr`, in, 32: data byte address.
- `i_d_wdata`, in, 32: write word, big-endian (byte `addr` = bits 31:24).
- `o_d_ack`, out, 1: one-cycle completion pulse for D.
- `o_d_rdata`, out, 32: data read word; valid with `o_d_ack` and held. Unchanged by writes.
- `o_d_err`, out, 1: out-of-range flag; valid with `o_d_ack`.
- `o_ram_do`, out, 2: to `ram.i_do`. Values are `RAM_NONE`/`RAM_READ`/`RAM_WRITE`.
- `o_ram_addr`, out, 32: to `ram.i_addr`.
- `o_ram_val`, out, 32: to `ram.i_val`.
- `i_ram_val`, in, 32: from `ram.o_val`.

## Operation
- Encoding: `RAM_NONE`=2'b00, `RAM_READ`=2'b01, `RAM_WRITE`=2'b10.
- FSM states: IDLE, ACCESS, DONE.
- **IDLE**
  - If any request is present: pick a winner, latch its op/addr/wdata into the issue registers and latch the port id, then go to ACCESS.
  - Otherwise stay in IDLE.
- **Range check**: a request is legal iff `addr <= MEM_SIZE-4`, unsigned 32-bit compare. `addr` values near 2^32 must not wrap to legal.
- **ACCESS**
  - Legal request: `o_ram_do`=op, `o_ram_addr`/`o_ram_val` driven from the issue registers.
    - Read: `i_ram_val` is captured into the winner's rdata register at the end of the cycle.
    - Write: the RAM commits at that same edge.
  - Illegal request: `o_ram_do`=`RAM_NONE`. The winner's rdata is set to 0 and its err flag to 1.
  - Always go to DONE.
- **DONE**
  - Pulse the winner's ack with its err flag. The loser's ack stays 0.
  - Go to IDLE.
- **Re-request**: a requester holding req high in the cycle after its ack is treated as a new request.
- **Arbitration**: see Configuration. A lone requester always wins.
- **RAM port outside ACCESS**: `o_ram_do`=`RAM_NONE`. `o_ram_addr`/`o_ram_val` hold their last values.
- **Held outputs**: rdata registers change only on their own port's read completion.

## Timing
- Request sampled in IDLE at cycle 0 → ACCESS in cycle 1 → ack in cycle 2. Next IDLE sample is in cycle 3.
- Throughput: one access per 3 cycles, shared between F and D.
- The write is visible in RAM from the edge ending cycle 1.
- Reset values:
  - State IDLE.
  - All acks/errs 0, both rdata 0.
  - `o_ram_do`=`RAM_NONE`, `o_ram_addr`=0, `o_ram_val`=0.
  - Round-robin pointer = F, so D wins the first tie.
- Reset asserted mid-operation: immediate return to IDLE and `o_ram_do` forced to `RAM_NONE`.
  - A write in ACCESS is committed only if `i_rst_n` is still high at the closing edge.
  - No ack is issued for the aborted request.
- Request inputs changing while pending is a protocol violation; only the value latched in IDLE is used.

## Configuration
- `RAM_ARB_RR_EN` defined: round-robin. On a tie, grant the port that did not win the last grant. The pointer updates on every grant, including illegal-address grants.
- `RAM_ARB_RR_EN` undefined: fixed priority, D over F. No pointer register. F may starve under continuous D traffic.

## Structure
- Shared header/package holds `RAM_NONE`, `RAM_READ`, `RAM_WRITE`, `MEM_SIZE`, the FSM state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and the port ids (F=0, D=1).
- One sub-module, `ram_arb_pick`: combinational winner select from `{f_req, d_req, last_grant}` plus the `RAM_ARB_RR_EN` logic.
- FSM and registers live in `ram_arbiter`.

## Test plan
- **D write then D read**, `MEM_SIZE`=4096:
  - D writes 0xDEADBEEF to 0x10. Then D reads 0x10.
  - Required: `o_d_rdata`=0xDEADBEEF, ack 2 cycles after sample, `o_d_err`=0.
  - Byte 0x10 = 0xDE.
- **F read**: preload 0x100=0x12345678, F reads 0x100.
  - Required: `o_f_rdata`=0x12345678 with `o_f_ack`.
  - `o_d_rdata` unchanged.
- **Tie with `RAM_ARB_RR_EN`**: F and D held high from reset.
  - Required grant order D, F, D, F.
  - Acks at cycles 2, 5, 8, 11.
- **Tie without macro**: same stimulus.
  - Required: D acked every 3 cycles, F never acked while D is held.
  - F is acked 3 cycles after D drops.
- **Range check**:
  - D write to 4093 → `o_d_err`=1, `o_ram_do` stays `RAM_NONE`, RAM unchanged.
  - D read of 0xFFFFFFFE → err=1, rdata=0.
  - Read of 4092 → legal.
- **Reset mid-ACCESS**: assert `i_rst_n`=0 during a write ACCESS cycle.
  - Required: `o_ram_do`=`RAM_NONE` immediately, no commit, no ack.
  - All outputs at reset values.
